bitserial_alu_ctrl: RTL

// Sequencer for one systolic PE's bit-serial ALU. Accepts an operation via start/ready handshake,

---
 rtl/bitserial_alu_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/bitserial_alu_ctrl.sv
// Sequencer for one bit-serial ALU in a systolic PE: load, one shift per operand bit, present result.
// Latency: accept C0, LOAD C1, RUN C2..C(1+len), out_valid_o from C(2+len); zero length reaches DONE in C2.
// Backpressure: DONE holds out_valid_o until out_ready_i; start_i is only taken in IDLE and never queued.
module bitserial_alu_ctrl #(
    parameter int CNT_W   = 4,
    parameter int DEF_LEN = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             use_def_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cnt_val_i,
    output logic             cnt_ld_o,
    output logic [CNT_W-1:0] cnt_ld_val_o,
    output logic             cnt_decr_o,
    output logic             opnd_ld_o,
    output logic             shift_en_o,
    output logic             carry_clr_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEF_LEN_V = CNT_W'(DEF_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] len_q;
    logic             err_q;

    // Control sequencer: abort outranks every other transition outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q   <= (len_i == '0 && use_def_i) ? DEF_LEN_V : len_i;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (len_q == '0) begin
                        // Nothing to shift: report the zero length instead of running.
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_val_i == '0) begin
                        // Counter already empty while bits remain: external counter is out of step.
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_val_i == CNT_ONE) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (abort_i || out_ready_i) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the state register; load and decrement live in disjoint states.
    assign ready_o      = (state_q == S_IDLE);
    assign opnd_ld_o    = (state_q == S_LOAD);
    assign carry_clr_o  = (state_q == S_LOAD);
    assign cnt_ld_o     = (state_q == S_LOAD);
    assign cnt_ld_val_o = (state_q == S_LOAD) ? len_q : '0;
    assign shift_en_o   = (state_q == S_RUN);
    assign cnt_decr_o   = (state_q == S_RUN);
    assign busy_o       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign out_valid_o  = (state_q == S_DONE);
    assign err_o        = (state_q == S_DONE) && err_q;

endmodule
